// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, colour constants and coordinate type
package vga_pkg;
    localparam int COORD_W  = 12;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [2:0] COLOR_BLACK = 3'b000;
    localparam logic [2:0] COLOR_WHITE = 3'b111;
    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_wrap_counter.sv
// vga_wrap_counter: enabled 12-bit counter that wraps to 0 after terminal count TC
module vga_wrap_counter
    import vga_pkg::*;
#(
    parameter int TC = H_TOTAL - 1
) (
    input  logic   CLOCK_25,
    input  logic   RESET_N,
    input  logic   en,
    output coord_t q,
    output logic   wrap
);
    assign wrap = en && (q == coord_t'(TC));
    always_ff @(posedge CLOCK_25)
        if (!RESET_N) q <= '0;
        else if (en)  q <= wrap ? '0 : q + 1'b1;
endmodule

// File: rtl/vga_timing_out.sv
// vga_timing_out: raster counters, sync/active decode and registered, blanked VGA pins
module vga_timing_out
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter int   H_FP        = vga_pkg::H_FP,
    parameter int   H_SYNC      = vga_pkg::H_SYNC,
    parameter int   H_BP        = vga_pkg::H_BP,
    parameter int   V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter int   V_FP        = vga_pkg::V_FP,
    parameter int   V_SYNC      = vga_pkg::V_SYNC,
    parameter int   V_BP        = vga_pkg::V_BP,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       CLOCK_25,
    input  logic       RESET_N,
    input  logic [2:0] color_in,
    output coord_t     x,
    output coord_t     y,
    output logic       active,
    output logic       frame_start,
    output logic       vblank_start,
    output logic       hsync,
    output logic       vsync,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    logic h_wrap, unused_v_wrap, hs_raw, vs_raw;
    vga_wrap_counter #(.TC(H_TOTAL - 1)) u_h (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .en(1'b1),   .q(x), .wrap(h_wrap)
    );
    vga_wrap_counter #(.TC(V_TOTAL - 1)) u_v (
        .CLOCK_25(CLOCK_25), .RESET_N(RESET_N), .en(h_wrap), .q(y), .wrap(unused_v_wrap)
    );
    assign active       = (x < coord_t'(H_ACTIVE)) && (y < coord_t'(V_ACTIVE));
    assign frame_start  = (x == '0) && (y == '0);
    assign vblank_start = (x == '0) && (y == coord_t'(V_ACTIVE));
    assign hs_raw = (x >= coord_t'(H_ACTIVE + H_FP)) && (x < coord_t'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw = (y >= coord_t'(V_ACTIVE + V_FP)) && (y < coord_t'(V_ACTIVE + V_FP + V_SYNC));
    // sync and colour share one register stage so the pins stay aligned
    always_ff @(posedge CLOCK_25)
        if (!RESET_N) begin
            hsync               <= ~SYNC_ACTIVE;
            vsync               <= ~SYNC_ACTIVE;
            {vga_r,vga_g,vga_b} <= COLOR_BLACK;
        end else begin
            hsync               <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync               <= vs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            {vga_r,vga_g,vga_b} <= active ? color_in : COLOR_BLACK;
        end
endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: directed checks on full-size, inverted-sync and shrunken-timing instances
module tb_vga_timing_out;
    logic clk = 1'b0;
    always #20 clk = ~clk;
    logic rst_n, rst_s_n;
    logic [2:0] color_in;
    logic [11:0] x, y, x_i, y_i, x_s, y_s;
    logic active, frame_start, vblank_start, hsync, vsync, r, g, b;
    logic active_i, frame_start_i, vblank_start_i, hsync_i, vsync_i, r_i, g_i, b_i;
    logic active_s, frame_start_s, vblank_start_s, hsync_s, vsync_s, r_s, g_s, b_s;
    int vectors = 0, errors = 0;

    vga_timing_out dut (
        .CLOCK_25(clk), .RESET_N(rst_n), .color_in(color_in), .x(x), .y(y),
        .active(active), .frame_start(frame_start), .vblank_start(vblank_start),
        .hsync(hsync), .vsync(vsync), .vga_r(r), .vga_g(g), .vga_b(b)
    );
    vga_timing_out #(.SYNC_ACTIVE(1'b1)) dut_i (
        .CLOCK_25(clk), .RESET_N(rst_n), .color_in(color_in), .x(x_i), .y(y_i),
        .active(active_i), .frame_start(frame_start_i), .vblank_start(vblank_start_i),
        .hsync(hsync_i), .vsync(vsync_i), .vga_r(r_i), .vga_g(g_i), .vga_b(b_i)
    );
    // shrunken raster: 16 pixels x 12 lines so whole frames fit in a short run
    vga_timing_out #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_s (
        .CLOCK_25(clk), .RESET_N(rst_s_n), .color_in(color_in), .x(x_s), .y(y_s),
        .active(active_s), .frame_start(frame_start_s), .vblank_start(vblank_start_s),
        .hsync(hsync_s), .vsync(vsync_s), .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst_s_n = 1'b0; color_in = 3'b111;
        repeat (5) begin
            step();
            vectors++;
            if ({x, y} !== 24'd0) begin errors++; $display("FAIL rst_xy got x=%0d y=%0d exp 0 0", x, y); end
            vectors++;
            if ({hsync, vsync, r, g, b} !== 5'b11000) begin errors++; $display("FAIL rst_pins got %b exp 11000", {hsync, vsync, r, g, b}); end
            vectors++;
            if ({hsync_i, vsync_i} !== 2'b00) begin errors++; $display("FAIL rst_inv_sync got %b exp 00", {hsync_i, vsync_i}); end
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if ({frame_start, active, vblank_start} !== 3'b110) begin errors++; $display("FAIL rel_flags got %b exp 110", {frame_start, active, vblank_start}); end
    endtask

    task automatic test_one_line();
        int low = 0, first = -1;
        for (int c = 0; c <= 1600; c++) begin
            int pos = c % 800;
            logic exp_hs;
            logic [2:0] exp_rgb;
            if (c > 0) step();
            exp_hs  = !(pos >= 657 && pos <= 752);
            exp_rgb = (pos >= 1 && pos <= 640) ? ((c <= 800) ? 3'b111 : 3'b010) : 3'b000;
            vectors++;
            if (x !== 12'(pos) || y !== 12'(c / 800)) begin errors++; $display("FAIL line_xy c=%0d got %0d,%0d exp %0d,%0d", c, x, y, pos, c / 800); end
            vectors++;
            if (hsync !== exp_hs || hsync_i !== !exp_hs) begin errors++; $display("FAIL line_hs c=%0d got %b/%b exp %b/%b", c, hsync, hsync_i, exp_hs, !exp_hs); end
            vectors++;
            if ({r, g, b} !== exp_rgb) begin errors++; $display("FAIL line_rgb c=%0d got %b exp %b", c, {r, g, b}, exp_rgb); end
            vectors++;
            if (vsync !== 1'b1 || vsync_i !== 1'b0 || frame_start !== (c == 0) || vblank_start !== 1'b0) begin
                errors++; $display("FAIL line_misc c=%0d got vs=%b vsi=%b fs=%b vb=%b", c, vsync, vsync_i, frame_start, vblank_start);
            end
            if (c < 800 && hsync === 1'b0) begin low++; if (first < 0) first = c; end
            color_in = (c >= 799) ? 3'b010 : 3'b111;
        end
        vectors++;
        if (low != 96 || first != 657) begin errors++; $display("FAIL hs_width got %0d from %0d exp 96 from 657", low, first); end
    endtask

    task automatic test_reset_midline();
        color_in = 3'b111;
        repeat (700) step();
        vectors++;
        if (x !== 12'd700 || y !== 12'd2 || hsync !== 1'b0 || hsync_i !== 1'b1) begin
            errors++; $display("FAIL pre_rst got x=%0d y=%0d hs=%b hsi=%b exp 700 2 0 1", x, y, hsync, hsync_i);
        end
        rst_n = 1'b0;
        step();
        vectors++;
        if ({x, y} !== 24'd0 || hsync !== 1'b1 || hsync_i !== 1'b0 || {r, g, b} !== 3'b000) begin
            errors++; $display("FAIL mid_rst got x=%0d y=%0d hs=%b hsi=%b rgb=%b", x, y, hsync, hsync_i, {r, g, b});
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (frame_start !== 1'b1 || active !== 1'b1) begin errors++; $display("FAIL mid_rel got fs=%b act=%b exp 1 1", frame_start, active); end
        step();
        vectors++;
        if (x !== 12'd1 || frame_start !== 1'b0 || {r, g, b} !== 3'b111) begin
            errors++; $display("FAIL mid_resume got x=%0d fs=%b rgb=%b exp 1 0 111", x, frame_start, {r, g, b});
        end
    endtask

    task automatic test_small_frame();
        int low = 0, first = -1;
        color_in = 3'b111;
        rst_s_n = 1'b1;
        #1;
        for (int c = 0; c <= 384; c++) begin
            int xs = c % 16, ys = (c / 16) % 12, p = (c > 0) ? c - 1 : 0;
            int pxs = p % 16, pys = (p / 16) % 12;
            logic exp_hs, exp_vs, exp_act;
            logic [2:0] exp_rgb;
            if (c > 0) step();
            exp_act = xs < 8 && ys < 6;
            exp_hs  = !(c > 0 && pxs >= 10 && pxs <= 12);
            exp_vs  = !(c > 0 && pys >= 8 && pys <= 9);
            exp_rgb = (c > 0 && pxs < 8 && pys < 6) ? 3'b111 : 3'b000;
            vectors++;
            if (x_s !== 12'(xs) || y_s !== 12'(ys)) begin errors++; $display("FAIL sm_xy c=%0d got %0d,%0d exp %0d,%0d", c, x_s, y_s, xs, ys); end
            vectors++;
            if ({active_s, frame_start_s, vblank_start_s} !== {exp_act, c % 192 == 0, c % 192 == 96}) begin
                errors++; $display("FAIL sm_flags c=%0d got %b exp %b", c, {active_s, frame_start_s, vblank_start_s}, {exp_act, c % 192 == 0, c % 192 == 96});
            end
            vectors++;
            if ({hsync_s, vsync_s, r_s, g_s, b_s} !== {exp_hs, exp_vs, exp_rgb}) begin
                errors++; $display("FAIL sm_pins c=%0d got %b exp %b", c, {hsync_s, vsync_s, r_s, g_s, b_s}, {exp_hs, exp_vs, exp_rgb});
            end
            if (c >= 1 && c <= 192 && vsync_s === 1'b0) begin low++; if (first < 0) first = c; end
        end
        vectors++;
        if (low != 32 || first != 129) begin errors++; $display("FAIL sm_vs_width got %0d from %0d exp 32 from 129", low, first); end
    endtask

    task automatic test_small_reset();
        repeat (59) step();
        vectors++;
        if (x_s !== 12'd11 || y_s !== 12'd3 || hsync_s !== 1'b0) begin errors++; $display("FAIL sm_pre_rst got %0d,%0d hs=%b exp 11,3 0", x_s, y_s, hsync_s); end
        rst_s_n = 1'b0;
        step();
        vectors++;
        if ({x_s, y_s} !== 24'd0 || hsync_s !== 1'b1 || {r_s, g_s, b_s} !== 3'b000) begin
            errors++; $display("FAIL sm_rst got %0d,%0d hs=%b rgb=%b", x_s, y_s, hsync_s, {r_s, g_s, b_s});
        end
        rst_s_n = 1'b1;
        #1;
        vectors++;
        if (frame_start_s !== 1'b1 || active_s !== 1'b1) begin errors++; $display("FAIL sm_rel got fs=%b act=%b exp 1 1", frame_start_s, active_s); end
        step();
        vectors++;
        if (x_s !== 12'd1 || y_s !== 12'd0) begin errors++; $display("FAIL sm_resume got %0d,%0d exp 1,0", x_s, y_s); end
    endtask

    initial begin
        test_reset();
        test_one_line();
        test_reset_midline();
        test_small_frame();
        test_small_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Upstream and downstream neighbour of img_generator, implemented as one block.
- Generates the 640x480@60 Hz raster counters (x, y) that img_generator consumes.
- Takes img_generator's combinational 3-bit color back.
- Drives the registered VGA pins (hsync, vsync, r/g/b), with blanking applied and sync/colour aligned.
- Also supplies frame-rate event pulses for game logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of hsync/vsync (0 = active-low)

Ports:
- CLOCK_25  in  1  25 MHz pixel clock; the only clock
- RESET_N  in  1  synchronous, active-low reset
- color_in  in  3  {R,G,B} from img_generator for the current x,y
- x  out  12  horizontal counter, 0..H_TOTAL-1
- y  out  12  vertical counter, 0..V_TOTAL-1
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE
- frame_start  out  1  one-cycle pulse at x==0, y==0
- vblank_start  out  1  one-cycle pulse at x==0, y==V_ACTIVE
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- vga_r, vga_g, vga_b  out  1 each  registered, blanked colour

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Counter stage:
  - x and y are registers.
  - x increments each cycle; at H_TOTAL-1 it wraps to 0.
  - y increments only in the cycle x wraps; at V_TOTAL-1 (with x wrap) it wraps to 0.
  - No intermediate values are skipped. All arithmetic is 12-bit unsigned with no overflow.
- Decodes from the counters (combinational; same cycle as x,y):
  - active.
  - frame_start.
  - vblank_start.
  - hs_raw = (H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC), i.e. x in 656..751.
  - vs_raw = (V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC), i.e. y in 490..491. vs_raw is asserted for whole lines and changes only at x==0.
- Output stage (1-cycle latency):
  - hsync <= hs_raw ? SYNC_ACTIVE : ~SYNC_ACTIVE.
  - vsync likewise from vs_raw.
  - {vga_r,vga_g,vga_b} <= active ? color_in : 3'b000.
  - Sync and colour therefore share identical latency relative to x,y, so pins stay aligned.
- Reset, while RESET_N==0 at a clock edge:
  - x=0, y=0.
  - hsync=vsync=~SYNC_ACTIVE.
  - vga_r/g/b=0.
- Reset mid-frame: aborts the frame immediately.
  - The first cycle after release presents x=0, y=0 with frame_start=1 and active=1.
  - No sync pulse may be truncated into a glitch shorter than 1 cycle. Registered outputs simply deassert.
- Corner cases:
  - At x=H_TOTAL-1, y=V_TOTAL-1, the next cycle is (0,0).
  - frame_start and vblank_start are never high simultaneously.
  - color_in is ignored (forced 0) outside active, including img_generator's border at x==640/y==480.
- Frame length: 420000 cycles; line length: 800 cycles.

Decomposition:
- Package vga_pkg:
  - Timing constants: H_/V_ ACTIVE, FP, SYNC, BP, plus derived H_TOTAL and V_TOTAL.
  - Colour constants COLOR_BLACK=3'b000 and COLOR_WHITE=3'b111.
  - Coordinate width 12.
- One sub-module, vga_wrap_counter:
  - 12-bit counter with enable, terminal-count parameter, synchronous active-low reset and wrap output.
  - Instantiated twice: horizontal counter, enable=1; vertical counter, enable=horizontal wrap.

Test Plan:
- Reset hold 5 cycles, then release:
  - During reset: x=0, y=0, hsync=vsync=1, rgb=0.
  - First cycle after release: frame_start=1, active=1.
- Free run one line:
  - x goes 0..799 then 0; y goes 0->1 exactly at that wrap.
  - hsync pin low for the 96 cycles following x=656..751, i.e. sampled one cycle late.
- Free run a full frame:
  - frame_start period = 420000 cycles.
  - vsync low exactly 1600 cycles, starting 1 cycle after (x=0, y=490).
  - vblank_start fires at (0, 480).
- Drive color_in=3'b111 constantly:
  - rgb=111 exactly one cycle after each active (x,y).
  - rgb=000 one cycle after x=640..799 and on lines 480..524.
  - In particular the pin sampled after x=639 is 111 and after x=640 is 000.
- Assert RESET_N low for 1 cycle at (x=700, y=300), mid-hsync:
  - Next state is (0,0).
  - hsync pin returns to 1 one cycle later.
  - Counting resumes cleanly with frame_start=1.
- Override SYNC_ACTIVE=1:
  - Sync polarities invert; timing is identical to the previous scenarios.
